// File: rtl/memory_access_if.sv
// Bundles the execute-side input, data-bus request/response and writeback-side
// output of the memory stage; slave is the stage's view, master is its environment.
interface memory_access_if #(
  parameter int XLEN      = 64,
  parameter int NREG_BITS = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_aluout;
  logic [XLEN-1:0]      in_wdata;
  logic [NREG_BITS-1:0] in_dst;
  logic                 in_wen;
  logic                 in_memread;
  logic                 in_memwrite;
  logic [1:0]           in_size;
  logic                 in_unsigned;

  logic                 dreq_valid;
  logic [XLEN-1:0]      dreq_addr;
  logic [1:0]           dreq_size;
  logic [XLEN/8-1:0]    dreq_strobe;
  logic [XLEN-1:0]      dreq_data;
  logic                 dresp_data_ok;
  logic [XLEN-1:0]      dresp_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [NREG_BITS-1:0] out_dst;
  logic                 out_wen;
  logic [XLEN-1:0]      out_writedata;
  logic                 out_misalign;

  modport slave (
    input  in_valid, in_aluout, in_wdata, in_dst, in_wen, in_memread, in_memwrite,
    input  in_size, in_unsigned,
    output in_ready,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data,
    output out_valid, out_dst, out_wen, out_writedata, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_aluout, in_wdata, in_dst, in_wen, in_memread, in_memwrite,
    output in_size, in_unsigned,
    input  in_ready,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data,
    input  out_valid, out_dst, out_wen, out_writedata, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/memory_access.sv
// Pipeline memory stage: one data-bus transaction per load/store, registered result to writeback.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module memory_access #(
  parameter int XLEN      = 64,
  parameter int NREG_BITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  memory_access_if.slave  bus
);
  localparam int STRB = XLEN / 8;
  localparam int OFFW = $clog2(STRB);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  function automatic logic [STRB-1:0] f_strobe(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [STRB-1:0] m;
    m = '0;
    for (int i = 0; i < STRB; i++) begin
      m[i] = (i < (32'sd1 <<< size));
    end
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] f_load(input logic [XLEN-1:0] data, input logic [OFFW-1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] res;
    raw = data >> {off, 3'b000};
    case (size)
      2'd0:    res = {{(XLEN-8){raw[7] & ~uns}}, raw[7:0]};
      2'd1:    res = {{(XLEN-16){raw[15] & ~uns}}, raw[15:0]};
      2'd2:    res = {{(XLEN-32){raw[31] & ~uns}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  logic [0:0]           r_state;
  logic                 r_out_valid;
  logic [NREG_BITS-1:0] r_out_dst;
  logic                 r_out_wen;
  logic [XLEN-1:0]      r_out_writedata;
  logic                 r_out_misalign;
  logic                 r_dreq_valid;
  logic [XLEN-1:0]      r_dreq_addr;
  logic [1:0]           r_dreq_size;
  logic [STRB-1:0]      r_dreq_strobe;
  logic [XLEN-1:0]      r_dreq_data;
  logic [NREG_BITS-1:0] r_ld_dst;
  logic                 r_ld_wen;
  logic                 r_ld_is_load;
  logic                 r_ld_unsigned;
  logic [1:0]           r_ld_size;
  logic [OFFW-1:0]      r_ld_off;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_misalign;
  logic [OFFW-1:0]      w_off;

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = addr_lo[0];
      2'd2:    r = |addr_lo[1:0];
      default: r = |addr_lo[2:0];
    endcase
    return r;
  endfunction

  assign w_misalign = f_misaligned(bus.in_aluout[2:0], bus.in_size);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mem   = bus.in_memread || bus.in_memwrite;
  assign w_off      = bus.in_aluout[OFFW-1:0];

  // Stage FSM, bus request registers and writeback result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_out_valid     <= 1'b0;
      r_out_dst       <= '0;
      r_out_wen       <= 1'b0;
      r_out_writedata <= '0;
      r_out_misalign  <= 1'b0;
      r_dreq_valid    <= 1'b0;
      r_dreq_addr     <= '0;
      r_dreq_size     <= 2'd0;
      r_dreq_strobe   <= '0;
      r_dreq_data     <= '0;
      r_ld_dst        <= '0;
      r_ld_wen        <= 1'b0;
      r_ld_is_load    <= 1'b0;
      r_ld_unsigned   <= 1'b0;
      r_ld_size       <= 2'd0;
      r_ld_off        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mem && !w_misalign) begin
            r_state       <= ST_REQ;
            r_dreq_valid  <= 1'b1;
            r_dreq_addr   <= bus.in_aluout;
            r_dreq_size   <= bus.in_size;
            r_dreq_strobe <= bus.in_memwrite ? f_strobe(bus.in_size, w_off) : '0;
            r_dreq_data   <= bus.in_memwrite ? (bus.in_wdata << {w_off, 3'b000}) : '0;
            r_ld_dst      <= bus.in_dst;
            r_ld_wen      <= bus.in_wen;
            r_ld_is_load  <= bus.in_memread;
            r_ld_unsigned <= bus.in_unsigned;
            r_ld_size     <= bus.in_size;
            r_ld_off      <= w_off;
            r_out_valid   <= 1'b0;
          end else if (w_accept) begin
            // ALU result, or a trapped misaligned access reporting its address
            r_out_valid     <= 1'b1;
            r_out_dst       <= bus.in_dst;
            r_out_wen       <= w_misalign ? 1'b0 : bus.in_wen;
            r_out_writedata <= bus.in_aluout;
            r_out_misalign  <= w_misalign;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        ST_REQ: begin
          if (bus.dresp_data_ok) begin
            r_state         <= ST_IDLE;
            r_dreq_valid    <= 1'b0;
            r_out_valid     <= 1'b1;
            r_out_dst       <= r_ld_dst;
            r_out_wen       <= r_ld_is_load && r_ld_wen;
            r_out_writedata <= r_ld_is_load ? f_load(bus.dresp_data, r_ld_off, r_ld_size, r_ld_unsigned) : '0;
            r_out_misalign  <= 1'b0;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dreq_valid <= 1'b0;
          r_out_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.dreq_valid    = r_dreq_valid;
  assign bus.dreq_addr     = r_dreq_addr;
  assign bus.dreq_size     = r_dreq_size;
  assign bus.dreq_strobe   = r_dreq_strobe;
  assign bus.dreq_data     = r_dreq_data;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_dst       = r_out_dst;
  assign bus.out_wen       = r_out_wen;
  assign bus.out_writedata = r_out_writedata;
  assign bus.out_misalign  = r_out_misalign;
endmodule
